// File: rtl/grf_scoreboard.sv
// Hazard scoreboard and write-port sequencer for the 32x32 GRF.
// It tracks in-flight destinations in order and stalls issue on RAW/WAW hazards.
module grf_scoreboard #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          iss_valid,
    input  logic [4:0]    iss_rs,
    input  logic [4:0]    iss_rt,
    input  logic          iss_use_rs,
    input  logic          iss_use_rt,
    input  logic          iss_wr,
    input  logic [4:0]    iss_rd,
    output logic          iss_ready,
    input  logic          wb_valid,
    output logic          grf_we,
    output logic [4:0]    grf_a3,
    output logic [AW:0]   pending,
    output logic [31:0]   busy,
    output logic          err
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   busy_q, busy_d;
    logic [4:0]    queue_q [DEPTH];
    logic [4:0]    queue_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;

    logic hazard_s, wr_nz_s, full_s, nonempty_s, fire_s, enq_s, pop_s;

    // Issue/writeback decode; hazards use registered busy only (no bypass)
    always_comb begin
        hazard_s   = (iss_use_rs && busy_q[iss_rs]) ||
                     (iss_use_rt && busy_q[iss_rt]) ||
                     (iss_wr     && busy_q[iss_rd]);
        wr_nz_s    = iss_wr && (iss_rd != 5'd0);
        full_s     = (count_q == DEPTH_C);
        nonempty_s = (count_q != {(AW+1){1'b0}});
        iss_ready  = !reset && !flush && !hazard_s && !(wr_nz_s && full_s);
        fire_s     = iss_valid && iss_ready;
        enq_s      = fire_s && wr_nz_s;
        pop_s      = wb_valid && nonempty_s && !flush;
        grf_we     = pop_s;
        if (nonempty_s) begin
            grf_a3 = queue_q[head_q];
        end else begin
            grf_a3 = 5'd0;
        end
    end

    // Next-state computation for busy vector, queue, pointers and error flag
    always_comb begin
        busy_d  = busy_q;
        queue_d = queue_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            busy_d  = 32'd0;
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {(AW+1){1'b0}};
        end else begin
            if (wb_valid && !nonempty_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            // Set and clear never collide: WAW stall keeps busy regs out of issue
            if (pop_s) begin
                busy_d[queue_q[head_q]] = 1'b0;
                head_d = head_q + AW'(1);
            end else begin
                head_d = head_q;
            end
            if (enq_s) begin
                queue_d[tail_q] = iss_rd;
                busy_d[iss_rd]  = 1'b1;
                tail_d = tail_q + AW'(1);
            end else begin
                tail_d = tail_q;
            end
            case ({enq_s, pop_s})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 32'd0;
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {(AW+1){1'b0}};
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                queue_q[i] <= 5'd0;
            end
        end else begin
            busy_q  <= busy_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
            queue_q <= queue_d;
        end
    end

    assign busy    = busy_q;
    assign pending = count_q;
    assign err     = err_q;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed plus randomized bench for grf_scoreboard; the reference model
// keeps pending destinations in a plain queue and derives busy from it.
module tb_grf_scoreboard;

    logic        clk = 1'b0;
    logic        reset, flush, iss_valid, iss_use_rs, iss_use_rt, iss_wr, wb_valid;
    logic [4:0]  iss_rs, iss_rt, iss_rd;
    logic        iss_ready, grf_we, err;
    logic [4:0]  grf_a3;
    logic [2:0]  pending;
    logic [31:0] busy;

    int checks = 0;
    int errors = 0;

    logic [4:0] mq[$];
    bit         merr = 1'b0;

    grf_scoreboard #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .iss_valid(iss_valid), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .iss_use_rs(iss_use_rs), .iss_use_rt(iss_use_rt),
        .iss_wr(iss_wr), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .grf_we(grf_we), .grf_a3(grf_a3),
        .pending(pending), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = 32'd0;
        foreach (mq[i]) b[mq[i]] = 1'b1;
        return b;
    endfunction

    task automatic drive(input bit v, input bit urs, input logic [4:0] rs,
                         input bit urt, input logic [4:0] rt, input bit w,
                         input logic [4:0] d, input bit wb, input bit fl);
        iss_valid = v;  iss_use_rs = urs; iss_rs = rs;
        iss_use_rt = urt; iss_rt = rt; iss_wr = w; iss_rd = d;
        wb_valid = wb;  flush = fl;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // One clock: check combinational outputs against the model, advance model, check state
    task automatic tick();
        logic [31:0] mb;
        bit haz, exp_ready, pop;
        logic [4:0] exp_a3;
        @(negedge clk);
        mb = model_busy();
        haz = (iss_use_rs && mb[iss_rs]) || (iss_use_rt && mb[iss_rt]) || (iss_wr && mb[iss_rd]);
        exp_ready = !reset && !flush && !haz && !(iss_wr && iss_rd != 5'd0 && mq.size() == 4);
        pop = wb_valid && mq.size() != 0 && !flush;
        exp_a3 = (mq.size() != 0) ? mq[0] : 5'd0;
        chk("iss_ready", {31'd0, iss_ready}, {31'd0, exp_ready});
        chk("grf_we", {31'd0, grf_we}, {31'd0, pop});
        chk("grf_a3", {27'd0, grf_a3}, {27'd0, exp_a3});
        if (reset) begin
            mq.delete();
            merr = 1'b0;
        end else if (flush) begin
            mq.delete();
        end else begin
            if (wb_valid && mq.size() == 0) merr = 1'b1;
            if (pop) void'(mq.pop_front());
            if (iss_valid && exp_ready && iss_wr && iss_rd != 5'd0) mq.push_back(iss_rd);
        end
        @(posedge clk);
        #1;
        chk("busy", busy, model_busy());
        chk("pending", {29'd0, pending}, mq.size());
        chk("err", {31'd0, err}, {31'd0, merr});
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        tick();
        chk("rst_iss_ready", {31'd0, iss_ready}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_pending", {29'd0, pending}, 32'd0);
        reset = 1'b0;

        // Single write to $8
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0);
        tick();
        idle();
        chk("tp1_busy", busy, 32'h0000_0100);
        chk("tp1_pending", {29'd0, pending}, 32'd1);
        chk("tp1_a3", {27'd0, grf_a3}, 32'd8);

        // RAW stall on $8, released the cycle after writeback
        drive(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("raw_stall", {31'd0, iss_ready}, 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        chk("wb_we", {31'd0, grf_we}, 32'd1);
        chk("wb_a3", {27'd0, grf_a3}, 32'd8);
        tick();
        drive(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("raw_release", {31'd0, iss_ready}, 32'd1);
        tick();

        // Write to $0 is accepted but not tracked
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        chk("rd0_ready", {31'd0, iss_ready}, 32'd1);
        tick();
        chk("rd0_pending", {29'd0, pending}, 32'd0);
        chk("rd0_busy", busy, 32'd0);

        // Fill the queue, full-queue stall, non-writer accepted, in-order drain
        for (int r = 1; r <= 4; r++) begin
            drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'(r), 1'b0, 1'b0);
            tick();
        end
        chk("full_pending", {29'd0, pending}, 32'd4);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
        chk("full_stall", {31'd0, iss_ready}, 32'd0);
        drive(1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("full_nonwr", {31'd0, iss_ready}, 32'd1);
        tick();
        for (int r = 1; r <= 4; r++) begin
            drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
            chk("drain_a3", {27'd0, grf_a3}, 32'(r));
            tick();
        end
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
        tick();
        idle();
        chk("wrap_a3", {27'd0, grf_a3}, 32'd7);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();

        // Simultaneous issue and pop, then WAW stall
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        chk("fp_pending", {29'd0, pending}, 32'd1);
        chk("fp_busy", busy, 32'h0000_0400);
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b0, 1'b0);
        chk("waw_stall", {31'd0, iss_ready}, 32'd0);
        tick();

        // Flush with three pending, then stray writeback sets sticky err
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd11, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        chk("flush_we", {31'd0, grf_we}, 32'd0);
        tick();
        chk("flush_pending", {29'd0, pending}, 32'd0);
        chk("flush_busy", busy, 32'd0);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("err_sticky", {31'd0, err}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_cleared", {31'd0, err}, 32'd0);

        // Randomized traffic against the queue model
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
